lsu_arbiter: RTL and testbench
==============================

# lsu_arbiter

Two-port arbiter and sequencer that shares the single load/store unit between the core data port (port 0) and a secondary master such as a DMA or debug port (port 1). It arbitrates between the two ports and latches the winning request. It drives the LSU address, mode and store controls for exactly one transaction at a time, holds the LSU address stable across the load latency, and returns captured load data to the requester with a one-cycle valid pulse.

## Interface
- LD_LAT, 1, LSU load latency: cycles from address applied to `lsu_ld_data` valid; legal range 0..7.
- clock_i  in  1  system clock; all state updates on the rising edge.
- reset_ni  in  1  asynchronous, active-high reset; the `_ni` suffix is kept for codebase consistency, and the polarity is high.
- m0_req, m1_req  in  1  request; hold high with a stable payload until the matching gnt is seen.
- m0_we, m1_we  in  1  1 = store, 0 = load.
- m0_addr, m1_addr  in  32  byte address.
- m0_mode, m1_mode  in  2  access size: 00 byte, 01 half, 10 word; 11 is passed through unchanged.
- m0_unsigned, m1_unsigned  in  1  zero-extend loads.
- m0_wdata, m1_wdata  in  32  store data.
- m0_gnt, m1_gnt  out  1  one-cycle pulse marking payload accepted.
- m0_rvalid, m1_rvalid  out  1  one-cycle pulse marking load data returned.
- m0_rdata, m1_rdata  out  32  load data; held until that port's next load response.
- lsu_addr  out  32  to LSU addr.
- lsu_mem_mode  out  2  to LSU mem_mode.
- lsu_mem_unsigned  out  1  to LSU mem_unsigned.
- lsu_st_data  out  32  to LSU st_data.
- lsu_st_en  out  1  to LSU st_en.
- lsu_ld_data  in  32  from LSU ld_data.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states are IDLE, ISSUE, WAIT and RESP.
- **IDLE**
  - Samples m0_req/m1_req. If either is high, picks a winner, latches its payload into the lsu_* registers and records the owner, then goes to ISSUE.
  - With no request it stays in IDLE.
- **ISSUE** (1 cycle)
  - The owner's gnt is high.
  - lsu_st_en = 1 only for a store.
  - A store goes to IDLE.
  - A load goes to WAIT, or to RESP if LD_LAT = 0, in which case `lsu_ld_data` is captured at the end of ISSUE.
- **WAIT** (LD_LAT cycles)
  - A 3-bit counter counts down; lsu_addr/mode/unsigned are held constant.
  - `lsu_ld_data` is captured into the owner's rdata at the end of the last WAIT cycle, then the FSM goes to RESP.
- **RESP** (1 cycle)
  - The owner's rvalid is high, then the FSM goes to IDLE.
  - The non-owner's rdata is never modified.
- lsu_st_en is 0 in every state except a store's ISSUE cycle. The lsu_* outputs keep their last values in IDLE.
- Arbitration uses a last-grant pointer:
  - Tie: the port not granted last wins.
  - Single requester: that port wins.
  - The pointer updates on each grant.
- A request withdrawn before it is sampled in IDLE is ignored. A request raised while busy waits for the next IDLE.
- Payload is passed through unchanged: no alignment check, no masking; the LSU handles byte lanes.
- Reset (async, at any point, mid-transaction included):
  - FSM goes to IDLE; all gnt/rvalid/lsu_st_en/busy are forced to 0 immediately.
  - lsu_addr, lsu_st_data, rdata and lsu_mem_mode are cleared to 0.
  - The last-grant pointer is set to port 1.
  - The in-flight transaction is dropped with no response. The requester still holds req and is re-served after reset.

## Timing
- Request sampled in IDLE at cycle T: gnt and lsu_* drive in T+1.
- Store: lsu_st_en is high in T+1 only; the next grant can issue at T+3 at the earliest.
- Load: data is valid in cycle T+1+LD_LAT, captured at its end; rvalid is in T+2+LD_LAT.
  - With LD_LAT=1: rvalid at T+3, next sample at T+4.
- The requester may change payload or drop req from the cycle after gnt.
- Occupancy is 2 cycles per store and 3+LD_LAT cycles per load, counting from the sampling IDLE cycle.
- gnt and rvalid are registered outputs and never asserted for both ports in the same cycle.

## Configuration
- LSU_ARB_RR_EN
  - Defined: round-robin tie-break as described above.
  - Undefined: fixed priority, port 0 always wins ties. The last-grant pointer is not instantiated, and port 1 may starve while port 0 requests continuously.

## Test plan
- Port 0 word store, addr 0x0000_0010, data 0xDEAD_BEEF:
  - m0_gnt pulses at T+1.
  - lsu_st_en is high only at T+1 with lsu_addr=0x10 and lsu_st_data=0xDEADBEEF.
  - busy drops at T+2.
- Port 1 byte load, addr 0x2001, LD_LAT=1, LSU model returns 0x0000_00A5:
  - m1_rvalid pulses at T+3 with m1_rdata=0x000000A5.
  - lsu_addr is stable at 0x2001 for T+1..T+2.
  - m0_rdata is unchanged.
- Both ports request loads continuously with LSU_ARB_RR_EN defined:
  - Grants alternate, port 0 first after reset: 0,1,0,1.
  - With LSU_ARB_RR_EN undefined, all grants go to port 0.
- Store followed by a load to the same address 0x30 from the other port:
  - The load returns the stored value 0x1234_5678.
  - Exactly one lsu_st_en pulse is seen.
- reset_ni asserted mid-WAIT of a port 0 load:
  - Outputs go to 0 asynchronously and no m0_rvalid is seen.
  - After release with m0_req still high, the load is re-granted and completes.
- LD_LAT=0 build, port 0 word load:
  - m0_rvalid is at T+2.
  - rdata equals lsu_ld_data sampled during T+1.

Source files
------------

// File: rtl/lsu_arbiter.sv
// Two-port arbiter/sequencer sharing one load/store unit between the core (port 0) and a secondary master (port 1).
// Define LSU_ARB_RR_EN for round-robin tie-break; otherwise port 0 wins every tie.
module lsu_arbiter #(
    parameter int LD_LAT = 1
) (
    input  logic        clock_i,
    input  logic        reset_ni,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [1:0]  m0_mode,
    input  logic        m0_unsigned,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [1:0]  m1_mode,
    input  logic        m1_unsigned,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic [31:0] lsu_addr,
    output logic [1:0]  lsu_mem_mode,
    output logic        lsu_mem_unsigned,
    output logic [31:0] lsu_st_data,
    output logic        lsu_st_en,
    input  logic [31:0] lsu_ld_data,
    output logic        busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    localparam logic [2:0] CNT_INIT = (LD_LAT > 0) ? 3'(LD_LAT - 1) : 3'd0;

    state_t      r_state, w_next;
    logic        r_owner, r_we;
    logic [2:0]  r_cnt;
    logic [31:0] r_addr, r_st_data, r_rdata0, r_rdata1;
    logic [1:0]  r_mode;
    logic        r_unsigned;
    logic        r_m0_gnt, r_m1_gnt, r_m0_rvalid, r_m1_rvalid, r_st_en, r_busy;

    logic        w_grant, w_cap, w_pick1;

`ifdef LSU_ARB_RR_EN
    logic r_last;

    always_ff @(posedge clock_i or posedge reset_ni) begin
        if (reset_ni)     r_last <= 1'b1;
        else if (w_grant) r_last <= w_pick1;
    end

    // On a tie the port that did not win last time gets the LSU.
    assign w_pick1 = m1_req & (~m0_req | ~r_last);
`else
    assign w_pick1 = m1_req & ~m0_req;
`endif

    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        w_cap   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (m0_req | m1_req) begin
                    w_grant = 1'b1;
                    w_next  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (r_we) begin
                    w_next = S_IDLE;
                end else if (LD_LAT == 0) begin
                    w_cap  = 1'b1;
                    w_next = S_RESP;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 3'd0) begin
                    w_cap  = 1'b1;
                    w_next = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_ni) begin
        if (reset_ni) begin
            r_state     <= S_IDLE;
            r_owner     <= 1'b0;
            r_we        <= 1'b0;
            r_cnt       <= 3'd0;
            r_addr      <= '0;
            r_mode      <= '0;
            r_unsigned  <= 1'b0;
            r_st_data   <= '0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
            r_m0_gnt    <= 1'b0;
            r_m1_gnt    <= 1'b0;
            r_m0_rvalid <= 1'b0;
            r_m1_rvalid <= 1'b0;
            r_st_en     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_grant) begin
                r_owner    <= w_pick1;
                r_we       <= w_pick1 ? m1_we       : m0_we;
                r_addr     <= w_pick1 ? m1_addr     : m0_addr;
                r_mode     <= w_pick1 ? m1_mode     : m0_mode;
                r_unsigned <= w_pick1 ? m1_unsigned : m0_unsigned;
                r_st_data  <= w_pick1 ? m1_wdata    : m0_wdata;
            end
            // Counter is loaded during ISSUE so WAIT lasts exactly LD_LAT cycles.
            if (r_state == S_ISSUE)     r_cnt <= CNT_INIT;
            else if (r_state == S_WAIT) r_cnt <= r_cnt - 3'd1;
            if (w_cap) begin
                if (r_owner) r_rdata1 <= lsu_ld_data;
                else         r_rdata0 <= lsu_ld_data;
            end
            r_m0_gnt    <= w_grant & ~w_pick1;
            r_m1_gnt    <= w_grant & w_pick1;
            r_st_en     <= w_grant & (w_pick1 ? m1_we : m0_we);
            r_m0_rvalid <= w_cap & ~r_owner;
            r_m1_rvalid <= w_cap & r_owner;
            r_busy      <= (w_next != S_IDLE);
        end
    end

    assign m0_gnt           = r_m0_gnt;
    assign m1_gnt           = r_m1_gnt;
    assign m0_rvalid        = r_m0_rvalid;
    assign m1_rvalid        = r_m1_rvalid;
    assign m0_rdata         = r_rdata0;
    assign m1_rdata         = r_rdata1;
    assign lsu_addr         = r_addr;
    assign lsu_mem_mode     = r_mode;
    assign lsu_mem_unsigned = r_unsigned;
    assign lsu_st_data      = r_st_data;
    assign lsu_st_en        = r_st_en;
    assign busy             = r_busy;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Directed bench for lsu_arbiter: main instance with LD_LAT=1 plus an LD_LAT=0 instance for the zero-latency path.
module tb_lsu_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        m0_req = 0, m0_we = 0, m0_uns = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0;
    logic [1:0]  m0_mode = 0;
    logic        m1_req = 0, m1_we = 0, m1_uns = 0;
    logic [31:0] m1_addr = 0, m1_wdata = 0;
    logic [1:0]  m1_mode = 0;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] lsu_addr, lsu_st_data, lsu_ld_data;
    logic [1:0]  lsu_mem_mode;
    logic        lsu_mem_unsigned, lsu_st_en, busy;

    // simple LSU model: small store-backed memory, one fixed byte at 0x2001
    logic [31:0] mem [64];
    always @(posedge clk) if (lsu_st_en) mem[lsu_addr[5:0]] <= lsu_st_data;
    assign lsu_ld_data = (lsu_addr == 32'h2001) ? 32'h0000_00A5 : mem[lsu_addr[5:0]];

    lsu_arbiter #(.LD_LAT(1)) u_dut (
        .clock_i(clk), .reset_ni(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_mode(m0_mode),
        .m0_unsigned(m0_uns), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_mode(m1_mode),
        .m1_unsigned(m1_uns), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .lsu_addr(lsu_addr), .lsu_mem_mode(lsu_mem_mode), .lsu_mem_unsigned(lsu_mem_unsigned),
        .lsu_st_data(lsu_st_data), .lsu_st_en(lsu_st_en), .lsu_ld_data(lsu_ld_data), .busy(busy)
    );

    logic        z_req = 0;
    logic [31:0] z_addr_in = 0;
    logic        z_m0_gnt, z_m1_gnt, z_m0_rv, z_m1_rv, z_uns, z_st_en, z_busy;
    logic [31:0] z_m0_rdata, z_m1_rdata, z_addr, z_st_data, z_ld;
    logic [1:0]  z_mode;
    assign z_ld = z_addr ^ 32'h5A5A_0000;

    lsu_arbiter #(.LD_LAT(0)) u_dut_z (
        .clock_i(clk), .reset_ni(rst),
        .m0_req(z_req), .m0_we(1'b0), .m0_addr(z_addr_in), .m0_mode(2'b10),
        .m0_unsigned(1'b0), .m0_wdata(32'h0), .m0_gnt(z_m0_gnt),
        .m0_rvalid(z_m0_rv), .m0_rdata(z_m0_rdata),
        .m1_req(1'b0), .m1_we(1'b0), .m1_addr(32'h0), .m1_mode(2'b00),
        .m1_unsigned(1'b0), .m1_wdata(32'h0), .m1_gnt(z_m1_gnt),
        .m1_rvalid(z_m1_rv), .m1_rdata(z_m1_rdata),
        .lsu_addr(z_addr), .lsu_mem_mode(z_mode), .lsu_mem_unsigned(z_uns),
        .lsu_st_data(z_st_data), .lsu_st_en(z_st_en), .lsu_ld_data(z_ld), .busy(z_busy)
    );

    int n_chk = 0, n_err = 0;
    int st_cnt = 0, rv0_cnt = 0;
    always @(posedge clk) begin
        if (lsu_st_en) st_cnt <= st_cnt + 1;
        if (m0_rvalid) rv0_cnt <= rv0_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic wait_gnt(input bit port);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (port ? m1_gnt : m0_gnt) seen = 1;
        end
        check("gnt_wait", {31'b0, seen}, 32'd1);
    endtask

    task automatic wait_rv(input bit port);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (port ? m1_rvalid : m0_rvalid) seen = 1;
        end
        check("rvalid_wait", {31'b0, seen}, 32'd1);
    endtask

    task automatic wait_idle();
        bit idle = 0;
        for (int i = 0; i < 20 && !idle; i++) begin
            @(negedge clk);
            if (!busy) idle = 1;
        end
        check("idle_wait", {31'b0, idle}, 32'd1);
    endtask

    initial begin
        logic [31:0] r0_keep, zs;
        logic [3:0]  seq, exp_seq;
        int          ng, rv_before, st_before;

        #3;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_addr", lsu_addr, 32'd0);
        check("rst_gnt",  {30'b0, m1_gnt, m0_gnt}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 0;

        // port 0 word store
        m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'hDEAD_BEEF; m0_mode = 2'b10;
        @(negedge clk);
        check("st_gnt0",  {31'b0, m0_gnt}, 32'd1);
        check("st_gnt1",  {31'b0, m1_gnt}, 32'd0);
        check("st_en_t1", {31'b0, lsu_st_en}, 32'd1);
        check("st_addr",  lsu_addr, 32'h10);
        check("st_data",  lsu_st_data, 32'hDEAD_BEEF);
        m0_req = 0;
        @(negedge clk);
        check("st_en_t2", {31'b0, lsu_st_en}, 32'd0);
        check("st_busy",  {31'b0, busy}, 32'd0);
        check("st_gnt_t2", {31'b0, m0_gnt}, 32'd0);

        // port 1 byte load, LD_LAT=1
        r0_keep = m0_rdata;
        m1_req = 1; m1_we = 0; m1_addr = 32'h2001; m1_mode = 2'b00; m1_uns = 1;
        @(negedge clk);
        check("ld_gnt1",  {31'b0, m1_gnt}, 32'd1);
        check("ld_addr1", lsu_addr, 32'h2001);
        check("ld_mode",  {30'b0, lsu_mem_mode}, 32'd0);
        check("ld_st_en", {31'b0, lsu_st_en}, 32'd0);
        m1_req = 0;
        @(negedge clk);
        check("ld_addr2", lsu_addr, 32'h2001);
        check("ld_rv_early", {31'b0, m1_rvalid}, 32'd0);
        @(negedge clk);
        check("ld_rv1",   {31'b0, m1_rvalid}, 32'd1);
        check("ld_rdata1", m1_rdata, 32'h0000_00A5);
        check("ld_rv0",   {31'b0, m0_rvalid}, 32'd0);
        check("ld_r0_keep", m0_rdata, r0_keep);
        @(negedge clk);
        check("ld_rv_end", {31'b0, m1_rvalid}, 32'd0);
        check("ld_busy",  {31'b0, busy}, 32'd0);
        check("ld_hold",  m1_rdata, 32'h0000_00A5);

        // both ports load continuously after a fresh reset
        rst = 1; @(negedge clk); rst = 0;
        m0_req = 1; m0_we = 0; m0_addr = 32'h10;
        m1_req = 1; m1_we = 0; m1_addr = 32'h2001;
        seq = '0; ng = 0;
        for (int i = 0; i < 40 && ng < 4; i++) begin
            @(negedge clk);
            if (m0_gnt & m1_gnt) check("gnt_both", 32'd1, 32'd0);
            if (m0_gnt | m1_gnt) begin
                seq[ng] = m1_gnt;
                ng++;
            end
        end
        m0_req = 0; m1_req = 0;
        check("arb_count", ng, 32'd4);
`ifdef LSU_ARB_RR_EN
        exp_seq = 4'b1010;
`else
        exp_seq = 4'b0000;
`endif
        check("arb_seq", {28'b0, seq}, {28'b0, exp_seq});
        wait_idle();

        // store then load same address from the other port
        st_before = st_cnt;
        m0_req = 1; m0_we = 1; m0_addr = 32'h30; m0_wdata = 32'h1234_5678;
        wait_gnt(0);
        m0_req = 0;
        m1_req = 1; m1_we = 0; m1_addr = 32'h30; m1_mode = 2'b10; m1_uns = 0;
        wait_gnt(1);
        m1_req = 0;
        wait_rv(1);
        check("raw_data", m1_rdata, 32'h1234_5678);
        check("raw_st_cnt", st_cnt - st_before, 32'd1);
        wait_idle();

        // reset during WAIT of a port 0 load
        m0_req = 1; m0_we = 0; m0_addr = 32'h10; m0_mode = 2'b10;
        @(negedge clk);
        check("rw_gnt", {31'b0, m0_gnt}, 32'd1);
        @(negedge clk);
        check("rw_busy_wait", {31'b0, busy}, 32'd1);
        rv_before = rv0_cnt;
        #2 rst = 1;
        #1;
        check("rw_busy_async", {31'b0, busy}, 32'd0);
        check("rw_addr_async", lsu_addr, 32'd0);
        check("rw_rdata_clr", m0_rdata, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 0;
        check("rw_no_rvalid", rv0_cnt - rv_before, 32'd0);
        wait_gnt(0);
        m0_req = 0;
        wait_rv(0);
        check("rw_reload", m0_rdata, 32'hDEAD_BEEF);
        wait_idle();

        // LD_LAT=0 word load
        z_req = 1; z_addr_in = 32'h40;
        @(negedge clk);
        check("z_gnt", {31'b0, z_m0_gnt}, 32'd1);
        check("z_rv_early", {31'b0, z_m0_rv}, 32'd0);
        zs = z_ld;
        z_req = 0;
        @(negedge clk);
        check("z_rv", {31'b0, z_m0_rv}, 32'd1);
        check("z_rdata", z_m0_rdata, zs);
        check("z_rdata_val", z_m0_rdata, 32'h5A5A_0040);
        @(negedge clk);
        check("z_rv_end", {31'b0, z_m0_rv}, 32'd0);
        check("z_busy", {31'b0, z_busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
